// File: rtl/flag_branch_unit_if.sv
// flag_branch_unit_if: ALU flag / branch request bundle between the pipeline and the flag/branch unit
interface flag_branch_unit_if #(parameter int OP_W = 4, parameter int FLAG_W = 3);
    logic              ex_valid;
    logic [OP_W-1:0]   ex_op;
    logic [FLAG_W-1:0] ex_flags;
    logic              br_valid;
    logic [2:0]        br_ccc;
    logic              stall;
    logic              flush;
    logic [FLAG_W-1:0] flag_q;
    logic              br_out_valid;
    logic              br_taken;
    modport master (
        output ex_valid, ex_op, ex_flags, br_valid, br_ccc, stall, flush,
        input  flag_q, br_out_valid, br_taken
    );
    modport slave (
        input  ex_valid, ex_op, ex_flags, br_valid, br_ccc, stall, flush,
        output flag_q, br_out_valid, br_taken
    );
endinterface

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: masked {Z,V,N} flag register with bypassed branch-condition evaluation and a registered decision
module flag_branch_unit #(
    parameter int OP_W   = 4,
    parameter int FLAG_W = 3
) (
    input logic clk,
    input logic rst_n,
    flag_branch_unit_if.slave bus
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_nxt;
    logic [FLAG_W-1:0] flag_r, eff;
    logic taken_r, taken_nxt, full, zonly, upd, br_acc, z, v, n;
    logic [7:0] cond;
    assign full   = bus.ex_op < OP_W'(2);
    assign zonly  = bus.ex_op inside {OP_W'(2), OP_W'(4), OP_W'(5), OP_W'(6)};
    assign upd    = bus.ex_valid & ~bus.stall & ~bus.flush;
    assign br_acc = bus.br_valid & ~bus.stall & ~bus.flush;
    // Same-cycle flag write is forwarded so the branch sees the post-update flags
    assign eff = !upd ? flag_r :
                 full ? bus.ex_flags :
                 zonly ? {bus.ex_flags[2], flag_r[1:0]} : flag_r;
    assign {z, v, n} = eff[2:0];
    assign cond = {1'b1, v, n | z, z | ~n, n, ~z & ~n, z, ~z};
    assign taken_nxt = br_acc & cond[bus.br_ccc];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            flag_r  <= '0;
            taken_r <= 1'b0;
        end else if (!bus.stall) begin
            state   <= state_nxt;
            flag_r  <= eff;
            taken_r <= taken_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        if (!bus.stall) state_nxt = br_acc ? RESP : IDLE;
    end
    always_comb begin
        bus.br_out_valid = state == RESP;
        bus.br_taken     = (state == RESP) & taken_r;
        bus.flag_q       = flag_r;
    end
endmodule
